bank_timing_array: RTL and testbench

BANK_TIMING_ARRAY -- requirements
Module: bank_timing_array

---
 rtl/bank_timing_array.sv | 182 ++++++++++++++++++
 tb/tb_bank_timing_array.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bank_timing_array.sv
// rtl/bank_timing_array.sv - multi-bank DRAM-style timing array with backing storage; TIMING_CHECK_EN enables command legality checks
`timescale 1ns/1ps
module bank_timing_array #(
    parameter int WIDTH     = 8,
    parameter int NUM_BANKS = 4,
    parameter int ROW_W     = 17,
    parameter int COL_W     = 10,
    parameter int ROW_STORE = 1,
    parameter int T_RCD     = 4,
    parameter int T_RP      = 4,
    parameter int T_CL      = 3,
    parameter int T_RFC     = 16,
    localparam int BANK_W   = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 halt,
    input  logic                 cmd_valid,
    input  logic [2:0]           cmd,
    input  logic [BANK_W-1:0]    bank,
    input  logic [ROW_W-1:0]     row,
    input  logic [COL_W-1:0]     column,
    input  logic [WIDTH-1:0]     wdata,
    output logic [WIDTH-1:0]     rdata,
    output logic                 rdata_valid,
    output logic                 cmd_ready,
    output logic                 err,
    output logic [NUM_BANKS-1:0] bank_open
);
    localparam int ADDR_W    = BANK_W + ROW_STORE + COL_W;
    localparam int MEM_DEPTH = NUM_BANKS << (ROW_STORE + COL_W);

    localparam logic [2:0] CMD_ACT = 3'd1;
    localparam logic [2:0] CMD_RD  = 3'd2;
    localparam logic [2:0] CMD_WR  = 3'd3;
    localparam logic [2:0] CMD_PR  = 3'd4;
    localparam logic [2:0] CMD_PRA = 3'd5;
    localparam logic [2:0] CMD_REF = 3'd6;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACTG   = 2'd1;
    localparam logic [1:0] S_ACTIVE = 2'd2;
    localparam logic [1:0] S_PRE    = 2'd3;

    // The accepting cycle counts as the first timed cycle, hence the -1 loads.
    localparam logic [5:0] RCD_LOAD = 6'(T_RCD - 1);
    localparam logic [5:0] RP_LOAD  = 6'(T_RP - 1);
    localparam logic [5:0] RFC_LOAD = 6'(T_RFC - 1);
    localparam logic [BANK_W-1:0] BANK_MASK = BANK_W'(NUM_BANKS - 1);

    logic [1:0]           state    [NUM_BANKS];
    logic [5:0]           cnt      [NUM_BANKS];
    logic [ROW_STORE-1:0] open_row [NUM_BANKS];
    logic                 refreshing;
    logic [5:0]           ref_cnt;
    logic [WIDTH-1:0]     mem      [MEM_DEPTH];
    logic [WIDTH-1:0]     pipe_d   [T_CL];
    logic                 pipe_v   [T_CL];

    logic [BANK_W-1:0]    sel;
    logic [ADDR_W-1:0]    addr;
    logic                 accept;
    logic                 exec;
    logic                 illegal;
    logic                 unused_row_bits;

    assign cmd_ready       = ~halt & ~rst;
    assign accept          = cmd_valid & cmd_ready;
    assign sel             = bank & BANK_MASK;
    assign addr            = {sel, open_row[sel], column};
    assign unused_row_bits = ^row;

`ifdef TIMING_CHECK_EN
    logic [1:0] sel_state;
    logic       all_idle;
    logic       legal;

    assign sel_state = state[sel];

    always_comb begin
        all_idle = 1'b1;
        for (int i = 0; i < NUM_BANKS; i++) begin
            if (state[i] != S_IDLE) all_idle = 1'b0;
        end
        legal = 1'b1;
        case (cmd)
            CMD_ACT:        legal = ~refreshing & (sel_state == S_IDLE);
            CMD_RD, CMD_WR: legal = ~refreshing & (sel_state == S_ACTIVE);
            CMD_PR:         legal = ~refreshing & ((sel_state == S_ACTIVE) | (sel_state == S_IDLE));
            CMD_REF:        legal = ~refreshing & all_idle;
            default:        legal = 1'b1;
        endcase
    end

    assign exec    = accept & legal;
    assign illegal = accept & ~legal;
`else
    assign exec    = accept;
    assign illegal = 1'b0;
`endif

    always_comb begin
        bank_open = '0;
        for (int i = 0; i < NUM_BANKS; i++) bank_open[i] = (state[i] == S_ACTIVE);
    end

    assign rdata       = pipe_d[T_CL-1];
    assign rdata_valid = pipe_v[T_CL-1] & ~halt;

    // Storage is deliberately outside the reset domain so contents survive rst.
    always_ff @(posedge clk) begin
        if (exec && cmd == CMD_WR) mem[addr] <= wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_BANKS; i++) begin
                state[i]    <= S_IDLE;
                cnt[i]      <= '0;
                open_row[i] <= '0;
            end
            for (int s = 0; s < T_CL; s++) begin
                pipe_d[s] <= '0;
                pipe_v[s] <= 1'b0;
            end
            refreshing <= 1'b0;
            ref_cnt    <= '0;
            err        <= 1'b0;
        end else begin
            err <= illegal;
            if (!halt) begin
                for (int i = 0; i < NUM_BANKS; i++) begin
                    if (state[i] == S_ACTG || state[i] == S_PRE) begin
                        if (cnt[i] <= 6'd1) begin
                            state[i] <= (state[i] == S_ACTG) ? S_ACTIVE : S_IDLE;
                            cnt[i]   <= '0;
                        end else begin
                            cnt[i] <= cnt[i] - 6'd1;
                        end
                    end
                    // Later assignments win: a command overrides the timer step above.
                    if (exec) begin
                        if (cmd == CMD_ACT && sel == BANK_W'(i)) begin
                            state[i]    <= (RCD_LOAD == 6'd0) ? S_ACTIVE : S_ACTG;
                            cnt[i]      <= RCD_LOAD;
                            open_row[i] <= row[ROW_STORE-1:0];
                        end
                        if (state[i] == S_ACTIVE &&
                            (cmd == CMD_PRA || (cmd == CMD_PR && sel == BANK_W'(i)))) begin
                            state[i] <= (RP_LOAD == 6'd0) ? S_IDLE : S_PRE;
                            cnt[i]   <= RP_LOAD;
                        end
                        if (cmd == CMD_REF) begin
                            state[i] <= S_IDLE;
                            cnt[i]   <= '0;
                        end
                    end
                end

                if (refreshing) begin
                    if (ref_cnt <= 6'd1) begin
                        refreshing <= 1'b0;
                        ref_cnt    <= '0;
                    end else begin
                        ref_cnt <= ref_cnt - 6'd1;
                    end
                end
                if (exec && cmd == CMD_REF) begin
                    refreshing <= (RFC_LOAD != 6'd0);
                    ref_cnt    <= RFC_LOAD;
                end

                pipe_v[0] <= exec && (cmd == CMD_RD);
                if (exec && cmd == CMD_RD) pipe_d[0] <= mem[addr];
                for (int s = 1; s < T_CL; s++) begin
                    pipe_v[s] <= pipe_v[s-1];
                    pipe_d[s] <= pipe_d[s-1];
                end
            end
        end
    end
endmodule

// File: tb/tb_bank_timing_array.sv
// tb/tb_bank_timing_array.sv - self-checking bench for bank_timing_array against a time-based reference model
`timescale 1ns/1ps
module tb_bank_timing_array;
    localparam int NB = 4, T_RCD = 4, T_RP = 4, T_CL = 3, T_RFC = 16;
`ifdef TIMING_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    logic        clk = 1'b0, rst = 1'b1, halt = 1'b0, cmd_valid = 1'b0;
    logic [2:0]  cmd = '0;
    logic [1:0]  bank = '0;
    logic [16:0] row = '0;
    logic [9:0]  column = '0;
    logic [7:0]  wdata = '0;
    logic [7:0]  rdata;
    logic        rdata_valid, cmd_ready, err;
    logic [3:0]  bank_open;

    bank_timing_array dut (
        .clk(clk), .rst(rst), .halt(halt), .cmd_valid(cmd_valid), .cmd(cmd),
        .bank(bank), .row(row), .column(column), .wdata(wdata),
        .rdata(rdata), .rdata_valid(rdata_valid), .cmd_ready(cmd_ready),
        .err(err), .bank_open(bank_open)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;

    // Model: bank state is derived from the time its last ACT/PR was issued.
    longint     mt = 0;
    int         m_phase [NB];
    longint     m_until [NB];
    bit         m_row   [NB];
    longint     ref_until = 0;
    logic [7:0] m_mem [int];
    longint     due_q [$];
    logic [7:0] dat_q [$];
    bit         err_exp = 1'b0;
    logic       obs_valid, obs_err;
    logic [7:0] obs_rdata;
    logic [3:0] obs_open;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int key(int b, bit rb, int col);
        return b * 2048 + int'(rb) * 1024 + col;
    endfunction

    function automatic int mstate(int b);
        if (m_phase[b] == 1) return (mt < m_until[b]) ? 1 : 2;
        if (m_phase[b] == 2) return (mt < m_until[b]) ? 3 : 0;
        return 0;
    endfunction

    function automatic logic [3:0] exp_open();
        logic [3:0] o;
        o = '0;
        for (int i = 0; i < NB; i++) o[i] = (mstate(i) == 2);
        return o;
    endfunction

    function automatic bit legal_m(logic [2:0] c, int b);
        bit rf, idle_all;
        rf = (mt < ref_until);
        idle_all = 1'b1;
        for (int i = 0; i < NB; i++) if (mstate(i) != 0) idle_all = 1'b0;
        case (c)
            3'd1:       return !rf && mstate(b) == 0;
            3'd2, 3'd3: return !rf && mstate(b) == 2;
            3'd4:       return !rf && (mstate(b) == 2 || mstate(b) == 0);
            3'd6:       return !rf && idle_all;
            default:    return 1'b1;
        endcase
    endfunction

    task automatic model_apply(input logic [2:0] c, input int b, input logic [16:0] r,
                               input int col, input logic [7:0] wd);
        bit lg;
        int st;
        lg = legal_m(c, b);
        st = mstate(b);
        err_exp = CHECK_EN && !lg;
        if (CHECK_EN && !lg) return;
        case (c)
            3'd1: begin m_phase[b] = 1; m_until[b] = mt + T_RCD; m_row[b] = r[0]; end
            3'd2: begin due_q.push_back(mt + T_CL); dat_q.push_back(m_mem[key(b, m_row[b], col)]); end
            3'd3: m_mem[key(b, m_row[b], col)] = wd;
            3'd4: if (st == 2) begin m_phase[b] = 2; m_until[b] = mt + T_RP; end
            3'd5: for (int i = 0; i < NB; i++)
                      if (mstate(i) == 2) begin m_phase[i] = 2; m_until[i] = mt + T_RP; end
            3'd6: begin ref_until = mt + T_RFC; for (int i = 0; i < NB; i++) m_phase[i] = 0; end
            default: ;
        endcase
    endtask

    task automatic model_reset();
        for (int i = 0; i < NB; i++) begin m_phase[i] = 0; m_until[i] = 0; m_row[i] = 1'b0; end
        ref_until = mt;
        due_q.delete();
        dat_q.delete();
        err_exp = 1'b0;
    endtask

    task automatic cyc(input logic v, input logic [2:0] c, input int b, input logic [16:0] r,
                       input int col, input logic [7:0] wd, input logic h);
        bit exp_v;
        @(posedge clk);
        #1;
        cmd_valid = v; cmd = c; bank = 2'(b); row = r; column = 10'(col); wdata = wd; halt = h;
        @(negedge clk);
        obs_valid = rdata_valid; obs_rdata = rdata; obs_err = err; obs_open = bank_open;
        check("cmd_ready", 32'(cmd_ready), 32'(!h));
        check("bank_open", 32'(bank_open), 32'(exp_open()));
        check("err", 32'(err), 32'(err_exp));
        exp_v = !h && due_q.size() > 0 && due_q[0] == mt;
        check("rdata_valid", 32'(rdata_valid), 32'(exp_v));
        if (exp_v) check("rdata", 32'(rdata), 32'(dat_q[0]));
        err_exp = 1'b0;
        if (!h) begin
            if (exp_v) begin void'(due_q.pop_front()); void'(dat_q.pop_front()); end
            if (v) model_apply(c, b, r, col, wd);
            mt++;
        end
    endtask

    task automatic nop(input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, 3'd0, 0, '0, 0, '0, 1'b0);
    endtask

    task automatic halt_cycles(input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, 3'd0, 0, '0, 0, '0, 1'b1);
    endtask

    initial begin
        model_reset();
        #2;
        check("reset_bank_open", 32'(bank_open), 32'h0);
        check("reset_rdata_valid", 32'(rdata_valid), 32'h0);
        check("reset_err", 32'(err), 32'h0);
        check("reset_rdata", 32'(rdata), 32'h0);
        check("reset_cmd_ready", 32'(cmd_ready), 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Fill every address the test uses so all reads have known data.
        for (int b = 0; b < NB; b++) begin
            for (int rb = 0; rb < 2; rb++) begin
                cyc(1'b1, 3'd1, b, 17'(rb), 0, '0, 1'b0);
                nop(3);
                for (int c = 0; c < 8; c++) cyc(1'b1, 3'd3, b, '0, c, 8'($urandom), 1'b0);
                cyc(1'b1, 3'd4, b, '0, 0, '0, 1'b0);
                nop(3);
            end
        end

        // ACT then RD exactly T_RCD later, data T_CL after.
        cyc(1'b1, 3'd1, 0, 17'd1, 0, '0, 1'b0);
        nop(3);
        cyc(1'b1, 3'd2, 0, '0, 5, '0, 1'b0);
        nop(2);
        check("req035_early", 32'(obs_valid), 32'h0);
        nop(1);
        check("req035_valid", 32'(obs_valid), 32'h1);
        check("req035_data", 32'(obs_rdata), 32'(m_mem[key(0, 1'b1, 5)]));
        check("req035_err", 32'(obs_err), 32'h0);

        // RD too early after ACT.
        cyc(1'b1, 3'd1, 1, 17'd0, 0, '0, 1'b0);
        nop(1);
        cyc(1'b1, 3'd2, 1, '0, 2, '0, 1'b0);
        nop(1);
        check("req036_err", 32'(obs_err), 32'(CHECK_EN));
        nop(4);

        // Write then immediate read of the same address.
        cyc(1'b1, 3'd1, 2, 17'd0, 0, '0, 1'b0);
        nop(3);
        cyc(1'b1, 3'd3, 2, '0, 7, 8'hA5, 1'b0);
        cyc(1'b1, 3'd2, 2, '0, 7, '0, 1'b0);
        nop(3);
        check("req037_valid", 32'(obs_valid), 32'h1);
        check("req037_data", 32'(obs_rdata), 32'hA5);

        // PRA closes all banks; REF then accepted; REF while refreshing rejected.
        cyc(1'b1, 3'd1, 3, 17'd1, 0, '0, 1'b0);
        nop(3);
        cyc(1'b1, 3'd5, 0, '0, 0, '0, 1'b0);
        nop(3);
        check("req038_closed", 32'(obs_open), 32'h0);
        cyc(1'b1, 3'd6, 0, '0, 0, '0, 1'b0);
        cyc(1'b1, 3'd6, 0, '0, 0, '0, 1'b0);
        check("req038_ref_ok", 32'(obs_err), 32'h0);
        nop(1);
        check("req038_ref_busy", 32'(obs_err), 32'(CHECK_EN));
        nop(T_RFC + 2);

        // Halt stretches read latency by the halted cycles.
        cyc(1'b1, 3'd1, 0, 17'd0, 0, '0, 1'b0);
        nop(3);
        cyc(1'b1, 3'd2, 0, '0, 3, '0, 1'b0);
        nop(1);
        halt_cycles(4);
        check("req039_halt_ready", 32'(cmd_ready), 32'h0);
        nop(1);
        check("req039_early", 32'(obs_valid), 32'h0);
        nop(1);
        check("req039_valid", 32'(obs_valid), 32'h1);
        check("req039_data", 32'(obs_rdata), 32'(m_mem[key(0, 1'b0, 3)]));

        // Random traffic.
        for (int k = 0; k < 600; k++) begin
            cyc(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), $urandom_range(0, 3),
                17'($urandom), $urandom_range(0, 7), 8'($urandom), ($urandom_range(0, 9) == 0));
        end

        // Quiesce, then reset mid-ACTIVATING with a read in flight.
        nop(T_RFC + 8);
        cyc(1'b1, 3'd5, 0, '0, 0, '0, 1'b0);
        nop(T_RP + T_RCD + 1);
        cyc(1'b1, 3'd5, 0, '0, 0, '0, 1'b0);
        nop(T_RP + 1);
        cyc(1'b1, 3'd1, 0, 17'd1, 0, '0, 1'b0);
        nop(3);
        cyc(1'b1, 3'd2, 0, '0, 5, '0, 1'b0);
        cyc(1'b1, 3'd1, 1, 17'd0, 0, '0, 1'b0);
        check("req040_open_before", 32'(obs_open[0]), 32'h1);
        @(posedge clk);
        #3;
        cmd_valid = 1'b0; halt = 1'b0; rst = 1'b1;
        #1;
        check("req040_bank_open", 32'(bank_open), 32'h0);
        check("req040_rdata_valid", 32'(rdata_valid), 32'h0);
        check("req040_err", 32'(err), 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        nop(2);
        cyc(1'b1, 3'd1, 0, 17'd1, 0, '0, 1'b0);
        nop(3);
        cyc(1'b1, 3'd2, 0, '0, 5, '0, 1'b0);
        nop(3);
        check("req040_valid_after", 32'(obs_valid), 32'h1);
        check("req040_data_kept", 32'(obs_rdata), 32'(m_mem[key(0, 1'b1, 5)]));
        nop(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
